// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per clock, MSB chunk first.
// Optional SERIAL_CMP_EARLY_EXIT_EN: finish at the first differing chunk instead of always scanning NCHUNK chunks.
module serial_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             e,
  output logic             g,
  output logic             s
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, a_n, b_q, b_n;
  logic             sm_q, sm_n;
  logic [IW-1:0]    idx, idx_n;
  logic             dec_gt, dec_gt_n, dec_lt, dec_lt_n;
  logic             busy_n, done_n, e_n, g_n, s_n;

  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CHUNK-1:0] chunk_a, chunk_b;
  logic             differ, step_gt, step_lt, finish;

  // Current chunk; in signed mode flipping the top bit turns two's complement into offset binary.
  always_comb begin
    sh_a    = a_q >> (CHUNK * int'(idx));
    sh_b    = b_q >> (CHUNK * int'(idx));
    chunk_a = sh_a[CHUNK-1:0];
    chunk_b = sh_b[CHUNK-1:0];
    if (sm_q && (idx == LAST)) begin
      chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
      chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
    end
    differ  = (chunk_a != chunk_b);
    step_gt = dec_gt | (!(dec_gt | dec_lt) && (chunk_a > chunk_b));
    step_lt = dec_lt | (!(dec_gt | dec_lt) && (chunk_a < chunk_b));
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    finish  = (idx == '0) || differ;
`else
    finish  = (idx == '0);
`endif
  end

  always_comb begin
    state_n  = state;
    a_n      = a_q;
    b_n      = b_q;
    sm_n     = sm_q;
    idx_n    = idx;
    dec_gt_n = dec_gt;
    dec_lt_n = dec_lt;
    busy_n   = busy;
    done_n   = 1'b0;
    e_n      = e;
    g_n      = g;
    s_n      = s;
    case (state)
      IDLE: begin
        if (start) begin
          state_n  = RUN;
          a_n      = a;
          b_n      = b;
          sm_n     = signed_mode;
          idx_n    = LAST;
          dec_gt_n = 1'b0;
          dec_lt_n = 1'b0;
          busy_n   = 1'b1;
          e_n      = 1'b0;
          g_n      = 1'b0;
          s_n      = 1'b0;
        end
      end
      RUN: begin
        dec_gt_n = step_gt;
        dec_lt_n = step_lt;
        idx_n    = idx - IW'(1);
        if (finish) begin
          state_n = IDLE;
          idx_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          e_n     = !(step_gt | step_lt);
          g_n     = step_gt;
          s_n     = step_lt;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sm_q   <= 1'b0;
      idx    <= '0;
      dec_gt <= 1'b0;
      dec_lt <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      e      <= 1'b0;
      g      <= 1'b0;
      s      <= 1'b0;
    end else begin
      state  <= state_n;
      a_q    <= a_n;
      b_q    <= b_n;
      sm_q   <= sm_n;
      idx    <= idx_n;
      dec_gt <= dec_gt_n;
      dec_lt <= dec_lt_n;
      busy   <= busy_n;
      done   <= done_n;
      e      <= e_n;
      g      <= g_n;
      s      <= s_n;
    end
  end

endmodule
